// File: rtl/shift_toggle_ctrl.sv
// Running-light controller: computes the toggle mask that walks one lit bit
// across a downstream TFF bank, once per prescaled step, with debounced switches.
//
// state | meaning
// SEED  | bank assumed clear; next step lights the end LED for the current direction
// RUN   | bank holds one lit LED; each step shifts it (wrap or ping-pong)
// FAULT | bank was seen corrupted; next step reseeds and clears stray bits
module shift_toggle_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 25000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sw_dir,
  input  logic             sw_mode,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_out,
  output logic             tick,
  output logic             dir_out,
  output logic [1:0]       state_out
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LOAD  = DW'(DB_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {SEED = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;

  // Index 0 is the direction switch, index 1 the mode switch.
  logic [1:0]    sw_raw, sync1, sync2, db_val;
  logic [DW-1:0] db_cnt [2];

  assign sw_raw = {sw_mode, sw_dir};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db_val <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= DB_LOAD;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_val[i]) begin
          db_cnt[i] <= DB_LOAD;
        end else if (db_cnt[i] == '0) begin
          db_val[i] <= sync2[i];
          db_cnt[i] <= DB_LOAD;
        end else begin
          db_cnt[i] <= db_cnt[i] - 1'b1;
        end
      end
    end
  end

  logic [PW-1:0] pre_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (pre_cnt == PRE_LAST) begin
          pre_cnt <= '0;
          tick    <= 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

  logic             step, q_onehot, run_dir, at_end, next_dir;
  logic [WIDTH-1:0] seed_pat, run_pat;

  assign step     = tick & en;
  assign q_onehot = (q_fb != '0) && ((q_fb & (q_fb - 1'b1)) == '0);

  // Ping-pong keeps the direction it already has; wrap follows the switch.
  always_comb begin
    seed_pat = db_val[0] ? ONE : MSB;
    run_dir  = db_val[1] ? dir_out : db_val[0];
    at_end   = run_dir ? q_fb[WIDTH-1] : q_fb[0];
    next_dir = run_dir ^ (db_val[1] & at_end);
    if (db_val[1] && at_end)
      run_pat = run_dir ? (q_fb >> 1) : (q_fb << 1);
    else if (at_end)
      run_pat = run_dir ? ONE : MSB;
    else
      run_pat = run_dir ? (q_fb << 1) : (q_fb >> 1);
  end

  state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SEED;
      t_out   <= '0;
      dir_out <= 1'b0;
    end else begin
      t_out <= '0;
      if (step) begin
        case (state)
          SEED, FAULT: begin
            t_out   <= q_fb ^ seed_pat;
            dir_out <= db_val[0];
            state   <= RUN;
          end
          RUN: begin
            if (q_onehot) begin
              t_out   <= q_fb ^ run_pat;
              dir_out <= next_dir;
            end else begin
              state <= FAULT;
            end
          end
          default: state <= SEED;
        endcase
      end
    end
  end

  assign state_out = state;

endmodule
